axi_slave_mem: RTL and testbench
================================

# axi_slave_mem

AXI3 slave responder backed by an internal word-addressed memory. It is the responder end of the AXI interface that our master agents and the assertion checker drive and observe. It accepts write and read bursts on five independent channels, returns OKAY or SLVERR responses, and holds every handshake well inside the checker's 5-cycle ready window.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width; 32 or 64
- ID_WIDTH, 4, transaction ID width
- MEM_DEPTH, 1024, memory depth in DATA_WIDTH words; power of two
- aclk  in  1  clock; all logic on its rising edge
- arst  in  1  reset; asynchronous assert, active-low
- awid/awaddr/awlen/awsize/awbrust  in  ID_WIDTH/ADDR_WIDTH/4/3/2  write address fields
- awvalid in 1, awready out 1  write address handshake
- wid/wdata/wstrb/wlast  in  ID_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1  write data fields
- wvalid in 1, wready out 1  write data handshake
- bid/bresp  out  ID_WIDTH/2  write response fields
- bvalid out 1, bready in 1  write response handshake
- arid/araddr/arlen/arsize/arbrust  in  same widths as aw*  read address fields
- arvalid in 1, arready out 1  read address handshake
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data fields
- rvalid out 1, rready in 1  read data handshake

## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE; read FSM R_IDLE -> R_DATA -> R_IDLE. The two FSMs run independently.
- W_IDLE: awready=1. On awvalid&awready, latch the aw fields, clear the beat counter, go to W_DATA.
- W_DATA: wready=1. Each wvalid&wready beat writes the bytes enabled by wstrb at the current address, then advances the address. The burst ends on beat index == awlen; then go to W_RESP.
- W_RESP: bvalid=1, bid=latched awid. Hold until bready; go to W_IDLE in the cycle after the handshake.
- bresp=SLVERR (2'b10) when any of these holds:
  - the burst is reserved (2'b11);
  - awsize > log2(DATA_WIDTH/8);
  - the burst is WRAP and awlen is not 1/3/7/15, or the start address is unaligned to the size;
  - any beat address falls outside MEM_DEPTH;
  - any wid != awid;
  - wlast does not match the final beat.
- On SLVERR, offending beats are not written. Otherwise bresp=OKAY (2'b00).
- R_IDLE: arready=1. On the handshake, latch the ar fields and go to R_DATA.
- R_DATA: rvalid=1, rid=latched arid, rlast=(beat==arlen).
  - Each beat: rdata = memory word and rresp = OKAY, or rdata = 0 and rresp = SLVERR under the same error rules as writes.
  - Advance on rvalid&rready. After the last handshake, go to R_IDLE.
- Address arithmetic:
  - FIXED: address held.
  - INCR: addr + (1<<size).
  - WRAP: wrap length = (len+1)<<size; the address wraps to the aligned boundary.
  - Word index = addr >> log2(DATA_WIDTH/8), modulo nothing: out-of-range indices are errors, not aliases.
- Same-cycle write beat and read fetch of the same word: the read returns the old data.
- Reset mid-burst: both FSMs return to idle and the burst is dropped with no response. Memory contents are not reset.

## Timing
- Reset values: awready=wready=arready=0, bvalid=rvalid=rlast=0, bid=rid=bresp=rresp=0, rdata=0. Ready signals rise the first cycle after arst deasserts.
- AW handshake to wready: 1 cycle.
- Last W beat to bvalid: 1 cycle.
- AR handshake to first rvalid: 1 cycle, with rdata registered.
- Back-to-back read beats: 1 per cycle when rready=1.
- While rvalid&!rready or bvalid&!bready, all payload outputs hold stable.
- awready stays low outside W_IDLE; arready stays low outside R_IDLE.

## Configuration
- AXI_SLV_BACKPRESSURE_EN defined: a 4-bit LFSR (seed 4'b1001, advanced every cycle) inserts a stall of lfsr[1:0] cycles (0-3) before each ready assertion (awready, wready per beat, arready). The stall never exceeds 3 cycles, so it stays within the 5-cycle checker window.
- Undefined: ready signals follow the FSM directly, as above, with no stalls.

## Structure
- Package axi_pkg holds:
  - burst encodings FIXED/INCR/WRAP/RSVD;
  - response constants OKAY/EXOKAY/SLVERR/DECERR;
  - the write and read FSM state enums.
- Sub-module axi_slv_addr_gen: combinational next-address and error-flag computation from addr/len/size/burst. It is instantiated once for writes and once for reads.

## Test plan
- INCR write: awaddr=0x10, awlen=3, awsize=2, data 0xA0..0xA3, wstrb=4'hF -> bresp=OKAY, bid=awid. Then an INCR read of the same range -> rdata 0xA0..0xA3, rlast on beat 3.
- WRAP read: araddr=0x38, arlen=3, arsize=2 -> addresses 0x38, 0x3C, 0x30, 0x34.
- Partial strobe: write 0xFFFFFFFF to 0x0, then write 0x12345678 with wstrb=4'b0101 -> read gives 0xFF34FF78.
- Out-of-range: awaddr=MEM_DEPTH*4 -> bresp=SLVERR, memory unchanged. A read at the same address -> rdata=0, rresp=SLVERR.
- Backpressure: hold rready=0 for 4 cycles mid-burst -> rdata/rid/rlast stable. Hold bready low -> bvalid held.
- Reset mid-burst: assert arst after write beat 1 of 4 -> all outputs 0. After release, a new single-beat write completes with OKAY.

Source files
------------

// File: rtl/axi_slave_mem_pkg.sv
// axi_pkg: AXI burst/response encodings and slave FSM state types
package axi_pkg;
   typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_t;
   localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;
endpackage

// File: rtl/axi_slave_mem_if.sv
// axi_slave_mem_if: five-channel AXI3 bus between a master agent and the memory slave
interface axi_slave_mem_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]     awid, wid, bid, arid, rid;
   logic [ADDR_WIDTH-1:0]   awaddr, araddr;
   logic [3:0]              awlen, arlen;
   logic [2:0]              awsize, arsize;
   logic [1:0]              awbrust, arbrust, bresp, rresp;
   logic                    awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic                    arvalid, arready, rvalid, rready, rlast;
   logic [DATA_WIDTH-1:0]   wdata, rdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   modport master (
      output awid, awaddr, awlen, awsize, awbrust, awvalid, input awready,
      output wid, wdata, wstrb, wlast, wvalid, input wready,
      input bid, bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arbrust, arvalid, input arready,
      input rid, rdata, rresp, rlast, rvalid, output rready
   );
   modport slave (
      input awid, awaddr, awlen, awsize, awbrust, awvalid, output awready,
      input wid, wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input arid, araddr, arlen, arsize, arbrust, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/axi_slave_mem_addr_gen.sv
// axi_slv_addr_gen: next beat address, word index and error flag for one burst beat
module axi_slv_addr_gen
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic [ADDR_WIDTH-1:0]        addr,
   input  logic [3:0]                   len,
   input  logic [2:0]                   size,
   input  burst_t                       burst,
   output logic [ADDR_WIDTH-1:0]        next_addr,
   output logic [$clog2(MEM_DEPTH)-1:0] idx,
   output logic                         err
);
   localparam int LG = $clog2(DATA_WIDTH / 8);
   localparam int IW = $clog2(MEM_DEPTH);
   logic [ADDR_WIDTH-1:0] step, wmask, inc, word;
   logic len_ok, unaligned, oob;
   // wrap keeps the high bits of the aligned window and wraps the low bits of addr+step
   always_comb begin
      step      = ADDR_WIDTH'(1) << size;
      wmask     = ((ADDR_WIDTH'(len) + 1'b1) << size) - 1'b1;
      inc       = addr + step;
      next_addr = burst == FIXED ? addr : burst == WRAP ? (addr & ~wmask) | (inc & wmask) : inc;
      word      = addr >> LG;
      idx       = word[IW-1:0];
      oob       = word >= ADDR_WIDTH'(MEM_DEPTH);
      len_ok    = len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15;
      unaligned = |(addr & (step - 1'b1));
      err       = burst == RSVD || size > 3'(LG) || (burst == WRAP && (!len_ok || unaligned)) || oob;
   end
endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI3 slave over an internal word memory; AXI_SLV_BACKPRESSURE_EN adds LFSR ready stalls
module axi_slave_mem
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_DEPTH  = 1024
) (
   input logic            aclk,
   input logic            arst,
   axi_slave_mem_if.slave bus
);
   localparam int IW = $clog2(MEM_DEPTH);
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   wstate_t ws, ws_n;
   rstate_t rs, rs_n;
   logic [ID_WIDTH-1:0]   aw_id, r_id;
   logic [ADDR_WIDTH-1:0] w_addr, r_next, wg_next, rg_next, rg_addr;
   logic [3:0]            aw_len, w_beat, ar_len, r_beat, rg_len;
   logic [2:0]            aw_size, ar_size, rg_size;
   burst_t                aw_burst, ar_burst, rg_burst;
   logic [IW-1:0]         wg_idx, rg_idx;
   logic [1:0]            b_resp, r_resp;
   logic [DATA_WIDTH-1:0] r_data;
   logic live, aw_go, w_go, ar_go, wg_err, rg_err, w_err, w_last, w_bad;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last, fetch;

   assign aw_hs  = bus.awvalid & bus.awready;
   assign w_hs   = bus.wvalid & bus.wready;
   assign b_hs   = bus.bvalid & bus.bready;
   assign ar_hs  = bus.arvalid & bus.arready;
   assign r_hs   = bus.rvalid & bus.rready;
   assign w_last = w_beat == aw_len;
   assign r_last = r_beat == ar_len;
   assign w_bad  = wg_err | (bus.wid != aw_id) | (bus.wlast != w_last);
   assign fetch  = ar_hs | (r_hs & ~r_last);
   assign bus.bid   = aw_id;
   assign bus.bresp = b_resp;
   assign bus.rid   = r_id;
   assign bus.rdata = r_data;
   assign bus.rresp = r_resp;

   // read fetch address: the request itself when idle, else the beat after the one on the bus
   assign rg_addr  = rs == R_IDLE ? bus.araddr : r_next;
   assign rg_len   = rs == R_IDLE ? bus.arlen : ar_len;
   assign rg_size  = rs == R_IDLE ? bus.arsize : ar_size;
   assign rg_burst = rs == R_IDLE ? burst_t'(bus.arbrust) : ar_burst;

   axi_slv_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_wgen (
      .addr(w_addr), .len(aw_len), .size(aw_size), .burst(aw_burst),
      .next_addr(wg_next), .idx(wg_idx), .err(wg_err)
   );
   axi_slv_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_rgen (
      .addr(rg_addr), .len(rg_len), .size(rg_size), .burst(rg_burst),
      .next_addr(rg_next), .idx(rg_idx), .err(rg_err)
   );

`ifdef AXI_SLV_BACKPRESSURE_EN
   logic [3:0] lfsr;
   logic [1:0] aw_cnt, w_cnt, ar_cnt;
   // stall counters reload from the LFSR at each handshake and count down while their ready is due
   always_ff @(posedge aclk or negedge arst)
      if (!arst) begin
         lfsr   <= 4'b1001;
         aw_cnt <= 2'b01;
         w_cnt  <= 2'b01;
         ar_cnt <= 2'b01;
      end else begin
         lfsr   <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
         aw_cnt <= aw_hs ? lfsr[1:0] : (aw_cnt != 2'd0 && ws == W_IDLE) ? aw_cnt - 1'b1 : aw_cnt;
         w_cnt  <= (aw_hs | w_hs) ? lfsr[1:0] : (w_cnt != 2'd0 && ws == W_DATA) ? w_cnt - 1'b1 : w_cnt;
         ar_cnt <= ar_hs ? lfsr[1:0] : (ar_cnt != 2'd0 && rs == R_IDLE) ? ar_cnt - 1'b1 : ar_cnt;
      end
   assign aw_go = aw_cnt == 2'd0;
   assign w_go  = w_cnt == 2'd0;
   assign ar_go = ar_cnt == 2'd0;
`else
   assign aw_go = 1'b1;
   assign w_go  = 1'b1;
   assign ar_go = 1'b1;
`endif

   // FSM state registers; live holds readies low until the first edge after reset release
   always_ff @(posedge aclk or negedge arst)
      if (!arst) begin
         ws   <= W_IDLE;
         rs   <= R_IDLE;
         live <= 1'b0;
      end else begin
         ws   <= ws_n;
         rs   <= rs_n;
         live <= 1'b1;
      end

   // next-state logic for the independent write and read FSMs
   always_comb begin
      ws_n = (ws == W_IDLE && aw_hs) ? W_DATA :
             (ws == W_DATA && w_hs && w_last) ? W_RESP :
             (ws == W_RESP && b_hs) ? W_IDLE : ws;
      rs_n = (rs == R_IDLE && ar_hs) ? R_DATA :
             (rs == R_DATA && r_hs && r_last) ? R_IDLE : rs;
   end

   // handshake outputs decoded from state
   always_comb begin
      bus.awready = live && ws == W_IDLE && aw_go;
      bus.wready  = ws == W_DATA && w_go;
      bus.bvalid  = ws == W_RESP;
      bus.arready = live && rs == R_IDLE && ar_go;
      bus.rvalid  = rs == R_DATA;
      bus.rlast   = rs == R_DATA && r_last;
   end

   // write burst context; the error is sticky so one bad beat poisons the response
   always_ff @(posedge aclk or negedge arst)
      if (!arst) begin
         aw_id    <= '0;
         w_addr   <= '0;
         aw_len   <= '0;
         aw_size  <= '0;
         aw_burst <= FIXED;
         w_beat   <= '0;
         w_err    <= 1'b0;
         b_resp   <= OKAY;
      end else begin
         if (aw_hs) begin
            aw_id    <= bus.awid;
            w_addr   <= bus.awaddr;
            aw_len   <= bus.awlen;
            aw_size  <= bus.awsize;
            aw_burst <= burst_t'(bus.awbrust);
            w_beat   <= '0;
            w_err    <= 1'b0;
         end
         if (w_hs) begin
            w_addr <= wg_next;
            w_beat <= w_beat + 1'b1;
            w_err  <= w_err | w_bad;
            if (w_last) b_resp <= (w_err | w_bad) ? SLVERR : OKAY;
         end
      end

   // byte-enabled memory write; erroneous beats are dropped
   always_ff @(posedge aclk)
      if (w_hs && !w_bad)
         for (int i = 0; i < DATA_WIDTH / 8; i++)
            if (bus.wstrb[i]) mem[wg_idx][8*i +: 8] <= bus.wdata[8*i +: 8];

   // read burst context and registered read data; a same-edge write is not yet visible
   always_ff @(posedge aclk or negedge arst)
      if (!arst) begin
         r_id     <= '0;
         ar_len   <= '0;
         ar_size  <= '0;
         ar_burst <= FIXED;
         r_beat   <= '0;
         r_next   <= '0;
         r_data   <= '0;
         r_resp   <= OKAY;
      end else begin
         if (ar_hs) begin
            r_id     <= bus.arid;
            ar_len   <= bus.arlen;
            ar_size  <= bus.arsize;
            ar_burst <= burst_t'(bus.arbrust);
            r_beat   <= '0;
         end
         if (r_hs) r_beat <= r_beat + 1'b1;
         if (fetch) begin
            r_data <= rg_err ? '0 : mem[rg_idx];
            r_resp <= rg_err ? SLVERR : OKAY;
            r_next <= rg_next;
         end
      end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed AXI write/read bursts checked by a response scoreboard
module tb_axi_slave_mem;
   import axi_pkg::*;
   logic aclk = 1'b0;
   logic arst = 1'b0;
   always #5 aclk = ~aclk;

   axi_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();
   axi_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(1024)) dut (
      .aclk(aclk), .arst(arst), .bus(bus)
   );

   typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_t;
   typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_t;
   b_t exp_b[$];
   r_t exp_r[$];
   b_t eb;
   r_t er;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
      end
   endtask

   // monitor: every completed B or R handshake is popped against the scoreboard
   always @(negedge aclk) begin
      if (arst && bus.bvalid && bus.bready) begin
         if (exp_b.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_unexpected: bid=0x%0h bresp=0x%0h with nothing expected", bus.bid, bus.bresp);
         end else begin
            eb = exp_b.pop_front();
            chk("bid", bus.bid, eb.id);
            chk("bresp", bus.bresp, eb.resp);
         end
      end
      if (arst && bus.rvalid && bus.rready) begin
         if (exp_r.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL r_unexpected: rdata=0x%0h with nothing expected", bus.rdata);
         end else begin
            er = exp_r.pop_front();
            chk("rid", bus.rid, er.id);
            chk("rdata", bus.rdata, er.data);
            chk("rresp", bus.rresp, er.resp);
            chk("rlast", bus.rlast, er.last);
         end
      end
   end

   task automatic send_aw(input [3:0] id, input [31:0] a, input [3:0] len, input [2:0] sz, input [1:0] bt);
      logic hs;
      int n;
      hs = 1'b0;
      n = 0;
      bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = a; bus.awlen = len; bus.awsize = sz; bus.awbrust = bt;
      while (!hs && n < 20) begin
         @(negedge aclk); hs = bus.awready;
         @(posedge aclk); #1; n++;
      end
      bus.awvalid = 1'b0;
      chk("aw_handshake", hs, 1);
   endtask

   task automatic send_w(input [3:0] id, input [31:0] d, input [3:0] strb, input logic last);
      logic hs;
      int n;
      hs = 1'b0;
      n = 0;
      bus.wvalid = 1'b1; bus.wid = id; bus.wdata = d; bus.wstrb = strb; bus.wlast = last;
      while (!hs && n < 20) begin
         @(negedge aclk); hs = bus.wready;
         @(posedge aclk); #1; n++;
      end
      bus.wvalid = 1'b0;
      chk("w_handshake", hs, 1);
   endtask

   task automatic wait_b(input int stall, input [3:0] id, input [1:0] resp);
      logic hs;
      int n;
      hs = 1'b0;
      n = 0;
      if (stall > 0) begin
         bus.bready = 1'b0;
         while (!hs && n < 20) begin
            @(negedge aclk); hs = bus.bvalid;
            @(posedge aclk); #1; n++;
         end
         repeat (stall) begin
            @(negedge aclk);
            chk("bvalid_hold", bus.bvalid, 1);
            chk("bid_hold", bus.bid, id);
            chk("bresp_hold", bus.bresp, resp);
            @(posedge aclk); #1;
         end
         bus.bready = 1'b1;
      end
      hs = 1'b0;
      n = 0;
      while (!hs && n < 20) begin
         @(negedge aclk); hs = bus.bvalid;
         @(posedge aclk); #1; n++;
      end
      chk("b_handshake", hs, 1);
   endtask

   task automatic wr(input [3:0] id, input [31:0] a, input [3:0] len, input [2:0] sz, input [1:0] bt,
                     input [31:0] base, input [3:0] strb, input [1:0] resp, input int bstall);
      exp_b.push_back('{id: id, resp: resp});
      send_aw(id, a, len, sz, bt);
      for (int i = 0; i <= int'(len); i++) send_w(id, base + 32'(i), strb, i == int'(len));
      wait_b(bstall, id, resp);
   endtask

   task automatic exp_rd(input [3:0] id, input [31:0] d, input [1:0] resp, input logic last);
      exp_r.push_back('{id: id, data: d, resp: resp, last: last});
   endtask

   task automatic rd(input [3:0] id, input [31:0] a, input [3:0] len, input [2:0] sz, input [1:0] bt,
                     input int stall_beat);
      logic hs, stalled;
      int n, beats;
      hs = 1'b0;
      stalled = 1'b0;
      n = 0;
      beats = 0;
      bus.arvalid = 1'b1; bus.arid = id; bus.araddr = a; bus.arlen = len; bus.arsize = sz; bus.arbrust = bt;
      while (!hs && n < 20) begin
         @(negedge aclk); hs = bus.arready;
         @(posedge aclk); #1; n++;
      end
      bus.arvalid = 1'b0;
      chk("ar_handshake", hs, 1);
      n = 0;
      while (beats <= int'(len) && n < 100) begin
         if (beats == stall_beat && !stalled) begin
            bus.rready = 1'b0;
            repeat (4) begin
               @(negedge aclk);
               chk("rvalid_hold", bus.rvalid, 1);
               if (exp_r.size() > 0) begin
                  chk("rid_hold", bus.rid, exp_r[0].id);
                  chk("rdata_hold", bus.rdata, exp_r[0].data);
                  chk("rlast_hold", bus.rlast, exp_r[0].last);
               end
               @(posedge aclk); #1;
            end
            bus.rready = 1'b1;
            stalled = 1'b1;
         end
         @(negedge aclk); if (bus.rvalid) beats++;
         @(posedge aclk); #1; n++;
      end
      chk("r_beats", beats, len + 1);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ready"}, {bus.awready, bus.wready, bus.arready}, 0);
      chk({nm, "_valid"}, {bus.bvalid, bus.rvalid, bus.rlast}, 0);
      chk({nm, "_payload"}, {bus.bid, bus.bresp, bus.rid, bus.rresp, bus.rdata}, 0);
   endtask

   initial begin
      bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awbrust = 0;
      bus.wvalid = 0; bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 1;
      bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arbrust = 0;
      bus.rready = 1;
      repeat (2) @(posedge aclk);
      #1;
      chk_zero("rst");
      arst = 1'b1;
      #1;
      chk("ready_before_edge", {bus.awready, bus.arready}, 0);
      @(posedge aclk); #1;
      chk("ready_after_edge", {bus.awready, bus.wready, bus.arready}, 3'b101);
      // INCR write then read back
      wr(4'd3, 32'h10, 4'd3, 3'd2, INCR, 32'hA0, 4'hF, OKAY, 0);
      for (int i = 0; i < 4; i++) exp_rd(4'd5, 32'hA0 + 32'(i), OKAY, i == 3);
      rd(4'd5, 32'h10, 4'd3, 3'd2, INCR, -1);
      // WRAP read from the middle of a 16-byte window
      wr(4'd1, 32'h30, 4'd3, 3'd2, INCR, 32'hB0, 4'hF, OKAY, 0);
      exp_rd(4'd2, 32'hB2, OKAY, 0);
      exp_rd(4'd2, 32'hB3, OKAY, 0);
      exp_rd(4'd2, 32'hB0, OKAY, 0);
      exp_rd(4'd2, 32'hB1, OKAY, 1);
      rd(4'd2, 32'h38, 4'd3, 3'd2, WRAP, -1);
      // partial strobe, with bready held low on the second write
      wr(4'd6, 32'h0, 4'd0, 3'd2, INCR, 32'hFFFF_FFFF, 4'hF, OKAY, 0);
      wr(4'd6, 32'h0, 4'd0, 3'd2, INCR, 32'h1234_5678, 4'b0101, OKAY, 3);
      exp_rd(4'd7, 32'hFF34_FF78, OKAY, 1);
      rd(4'd7, 32'h0, 4'd0, 3'd2, INCR, -1);
      // out of range: word 1024 must neither alias to word 0 nor read data
      wr(4'd7, 32'h1000, 4'd0, 3'd2, INCR, 32'hDEAD_BEEF, 4'hF, SLVERR, 0);
      exp_rd(4'd1, 32'hFF34_FF78, OKAY, 1);
      rd(4'd1, 32'h0, 4'd0, 3'd2, INCR, -1);
      exp_rd(4'd2, 32'h0, SLVERR, 1);
      rd(4'd2, 32'h1000, 4'd0, 3'd2, INCR, -1);
      // reserved burst type is an error
      exp_rd(4'd3, 32'h0, SLVERR, 1);
      rd(4'd3, 32'h10, 4'd0, 3'd2, RSVD, -1);
      // rready held low mid-burst
      for (int i = 0; i < 4; i++) exp_rd(4'd8, 32'hA0 + 32'(i), OKAY, i == 3);
      rd(4'd8, 32'h10, 4'd3, 3'd2, INCR, 1);
      // reset after the first of four write beats
      send_aw(4'd4, 32'h40, 4'd3, 3'd2, INCR);
      send_w(4'd4, 32'hD0, 4'hF, 1'b0);
      arst = 1'b0;
      #1;
      chk_zero("midrst");
      repeat (2) @(posedge aclk);
      #1;
      arst = 1'b1;
      @(posedge aclk); #1;
      wr(4'd9, 32'h44, 4'd0, 3'd2, INCR, 32'hC0, 4'hF, OKAY, 0);
      exp_rd(4'd6, 32'hC0, OKAY, 1);
      rd(4'd6, 32'h44, 4'd0, 3'd2, INCR, -1);
      repeat (3) @(posedge aclk);
      chk("b_queue_left", exp_b.size(), 0);
      chk("r_queue_left", exp_r.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      n_bad++;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end
endmodule
